// File: rtl/hdmi_packet_scheduler_if.sv
// Packet-source and data-island slot signals between the HDMI packet sources and the scheduler.
interface hdmi_packet_scheduler_if;
    logic                  clk_audio_counter_wrap;
    logic [23:0]           acr_header;
    logic [3:0][55:0]      acr_sub;
    logic                  audio_valid;
    logic [23:0]           audio_header;
    logic [3:0][55:0]      audio_sub;
    logic                  audio_ready;
    logic [23:0]           avi_header;
    logic [3:0][55:0]      avi_sub;
    logic [23:0]           aif_header;
    logic [3:0][55:0]      aif_sub;
    logic                  frame_start;
    logic                  packet_enable;
    logic [23:0]           header;
    logic [3:0][55:0]      sub;
    logic [2:0]            packet_type;
    logic                  acr_missed;

    modport master (
        output clk_audio_counter_wrap, acr_header, acr_sub,
        output audio_valid, audio_header, audio_sub,
        input  audio_ready,
        output avi_header, avi_sub, aif_header, aif_sub,
        output frame_start, packet_enable,
        input  header, sub, packet_type, acr_missed
    );

    modport slave (
        input  clk_audio_counter_wrap, acr_header, acr_sub,
        input  audio_valid, audio_header, audio_sub,
        output audio_ready,
        input  avi_header, avi_sub, aif_header, aif_sub,
        input  frame_start, packet_enable,
        output header, sub, packet_type, acr_missed
    );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// Chooses one packet per data-island slot from ACR, audio sample, AVI and audio infoframe sources.
module hdmi_packet_scheduler #(
    parameter int unsigned MAX_CONSECUTIVE_AUDIO = 3
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    hdmi_packet_scheduler_if.slave  bus
);

    localparam int unsigned RUN_RAW_W = $clog2(MAX_CONSECUTIVE_AUDIO + 1);
    localparam int unsigned RUN_W     = (RUN_RAW_W < 1) ? 1 : RUN_RAW_W;
    localparam int unsigned HDR_W     = 24;
    localparam int unsigned TYPE_W    = 3;

    localparam logic [TYPE_W-1:0] TYPE_NULL  = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_ACR   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_AUDIO = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TYPE_AVI   = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] TYPE_AIF   = TYPE_W'(4);

    localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(MAX_CONSECUTIVE_AUDIO);

    logic                prev_wrap_q;
    logic                acr_pending_q, acr_pending_d;
    logic                avi_pending_q, avi_pending_d;
    logic                aif_pending_q, aif_pending_d;
    logic                acr_missed_q,  acr_missed_d;
    logic [RUN_W-1:0]    audio_run_q,   audio_run_d;
    logic [HDR_W-1:0]    header_q,      header_d;
    logic [3:0][55:0]    sub_q,         sub_d;
    logic [TYPE_W-1:0]   type_q,        type_d;

    logic                acr_edge_c;
    logic                take_c;
    logic                acr_taken_c;
    logic                infoframe_pending_c;
    logic [TYPE_W-1:0]   sel_c;

    assign acr_edge_c          = bus.clk_audio_counter_wrap ^ prev_wrap_q;
    assign take_c              = bus.packet_enable & ~reset;
    assign infoframe_pending_c = avi_pending_q | aif_pending_q;
    assign acr_taken_c         = take_c && (sel_c == TYPE_ACR);

    // Priority pick from the flags as registered before this cycle.
    always_comb begin
        sel_c = TYPE_NULL;
        if (acr_pending_q) begin
            sel_c = TYPE_ACR;
        end else if (bus.audio_valid &&
                     ((audio_run_q < RUN_MAX) || !infoframe_pending_c)) begin
            sel_c = TYPE_AUDIO;
        end else if (avi_pending_q) begin
            sel_c = TYPE_AVI;
        end else if (aif_pending_q) begin
            sel_c = TYPE_AIF;
        end
    end

    assign bus.audio_ready = take_c && (sel_c == TYPE_AUDIO);

    // Pending flags: a set in the same cycle as the clear wins.
    always_comb begin
        acr_pending_d = acr_pending_q;
        avi_pending_d = avi_pending_q;
        aif_pending_d = aif_pending_q;
        acr_missed_d  = acr_missed_q;

        if (acr_taken_c) acr_pending_d = 1'b0;
        if (take_c && (sel_c == TYPE_AVI)) avi_pending_d = 1'b0;
        if (take_c && (sel_c == TYPE_AIF)) aif_pending_d = 1'b0;

        if (acr_edge_c) begin
            acr_pending_d = 1'b1;
            if (acr_pending_q && !acr_taken_c) acr_missed_d = 1'b1;
        end
        if (bus.frame_start) begin
            avi_pending_d = 1'b1;
            aif_pending_d = 1'b1;
        end
    end

    // Audio run length and the slot payload for the next cycle.
    always_comb begin
        audio_run_d = audio_run_q;
        header_d    = header_q;
        sub_d       = sub_q;
        type_d      = type_q;

        if (take_c) begin
            type_d = sel_c;
            if (sel_c == TYPE_AUDIO) begin
                audio_run_d = (audio_run_q == RUN_MAX) ? audio_run_q
                                                        : audio_run_q + RUN_W'(1);
            end else begin
                audio_run_d = '0;
            end
            unique case (sel_c)
                TYPE_ACR: begin
                    header_d = bus.acr_header;
                    sub_d    = bus.acr_sub;
                end
                TYPE_AUDIO: begin
                    header_d = bus.audio_header;
                    sub_d    = bus.audio_sub;
                end
                TYPE_AVI: begin
                    header_d = bus.avi_header;
                    sub_d    = bus.avi_sub;
                end
                TYPE_AIF: begin
                    header_d = bus.aif_header;
                    sub_d    = bus.aif_sub;
                end
                default: begin
                    header_d = '0;
                    sub_d    = '0;
                end
            endcase
        end
    end

    // Reset reloads prev_wrap from the live input so release never looks like an ACR edge.
    always_ff @(posedge clk_pixel) begin
        prev_wrap_q <= bus.clk_audio_counter_wrap;
        if (reset) begin
            acr_pending_q <= 1'b0;
            avi_pending_q <= 1'b0;
            aif_pending_q <= 1'b0;
            acr_missed_q  <= 1'b0;
            audio_run_q   <= '0;
            header_q      <= '0;
            sub_q         <= '0;
            type_q        <= TYPE_NULL;
        end else begin
            acr_pending_q <= acr_pending_d;
            avi_pending_q <= avi_pending_d;
            aif_pending_q <= aif_pending_d;
            acr_missed_q  <= acr_missed_d;
            audio_run_q   <= audio_run_d;
            header_q      <= header_d;
            sub_q         <= sub_d;
            type_q        <= type_d;
        end
    end

    assign bus.header      = header_q;
    assign bus.sub         = sub_q;
    assign bus.packet_type = type_q;
    assign bus.acr_missed  = acr_missed_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler: slot priority, ACR loss/overlap, audio run limit, reset.
module tb_hdmi_packet_scheduler;

    localparam logic [23:0] ACR_H = 24'h1A1A1A;
    localparam logic [23:0] AUD_H = 24'h2B2B2B;
    localparam logic [23:0] AVI_H = 24'h3C3C3C;
    localparam logic [23:0] AIF_H = 24'h4D4D4D;

    logic clk_pixel = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    hdmi_packet_scheduler_if ifc ();

    hdmi_packet_scheduler #(.MAX_CONSECUTIVE_AUDIO(3)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (ifc.slave)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic logic [23:0] hdr_of(input logic [2:0] t);
        case (t)
            3'd1:    return ACR_H;
            3'd2:    return AUD_H;
            3'd3:    return AVI_H;
            3'd4:    return AIF_H;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // One packet_enable pulse followed by one idle cycle; returns audio_ready seen in the enable cycle.
    task automatic slot(input logic av, output logic rdy);
        ifc.audio_valid   = av;
        ifc.packet_enable = 1'b1;
        #1;
        rdy = ifc.audio_ready;
        tick();
        ifc.packet_enable = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic rdy;
        ifc.clk_audio_counter_wrap = 1'b1;
        reset = 1'b1;
        ifc.packet_enable = 1'b1;
        ifc.audio_valid   = 1'b1;
        #1;
        checks++; if (ifc.audio_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ifc.audio_ready); else passed++;
        tick();
        tick();
        ifc.packet_enable = 1'b0;
        ifc.audio_valid   = 1'b0;
        reset = 1'b0;
        tick();
        checks++; if (ifc.packet_type !== 3'd0) $display("FAIL rst_type got %0d want 0", ifc.packet_type); else passed++;
        checks++; if (ifc.sub !== 224'd0) $display("FAIL rst_sub got %h want 0", ifc.sub); else passed++;
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd0) $display("FAIL rel_type got %0d want 0", ifc.packet_type); else passed++;
        checks++; if (ifc.header !== 24'h0) $display("FAIL rel_header got %h want 0", ifc.header); else passed++;
        checks++; if (ifc.acr_missed !== 1'b0) $display("FAIL rel_missed got %b want 0", ifc.acr_missed); else passed++;
    endtask

    task automatic test_priority();
        logic [2:0] exp_t [7] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd4};
        logic       exp_r [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       av    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic rdy;
        ifc.clk_audio_counter_wrap = ~ifc.clk_audio_counter_wrap;
        ifc.frame_start = 1'b1;
        ifc.audio_valid = 1'b1;
        tick();
        ifc.frame_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            slot(av[i], rdy);
            checks++; if (rdy !== exp_r[i]) $display("FAIL prio_ready[%0d] got %b want %b", i, rdy, exp_r[i]); else passed++;
            checks++; if (ifc.packet_type !== exp_t[i]) $display("FAIL prio_type[%0d] got %0d want %0d", i, ifc.packet_type, exp_t[i]); else passed++;
            checks++; if (ifc.header !== hdr_of(exp_t[i])) $display("FAIL prio_header[%0d] got %h want %h", i, ifc.header, hdr_of(exp_t[i])); else passed++;
        end
        checks++; if (ifc.sub !== {4{56'h44444444444444}}) $display("FAIL prio_aif_sub got %h", ifc.sub); else passed++;
        checks++; if (ifc.acr_missed !== 1'b0) $display("FAIL prio_missed got %b want 0", ifc.acr_missed); else passed++;
    endtask

    task automatic test_acr_missed();
        logic rdy;
        do_reset();
        ifc.clk_audio_counter_wrap = ~ifc.clk_audio_counter_wrap;
        tick();
        ifc.clk_audio_counter_wrap = ~ifc.clk_audio_counter_wrap;
        tick();
        checks++; if (ifc.acr_missed !== 1'b1) $display("FAIL miss_set got %b want 1", ifc.acr_missed); else passed++;
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd1) $display("FAIL miss_acr got %0d want 1", ifc.packet_type); else passed++;
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd0) $display("FAIL miss_once got %0d want 0", ifc.packet_type); else passed++;
        checks++; if (ifc.acr_missed !== 1'b1) $display("FAIL miss_sticky got %b want 1", ifc.acr_missed); else passed++;
        do_reset();
        checks++; if (ifc.acr_missed !== 1'b0) $display("FAIL miss_clear got %b want 0", ifc.acr_missed); else passed++;
    endtask

    task automatic test_back_to_back();
        logic rdy;
        do_reset();
        ifc.clk_audio_counter_wrap = ~ifc.clk_audio_counter_wrap;
        tick();
        // new edge lands in the very cycle the pending ACR is taken
        ifc.clk_audio_counter_wrap = ~ifc.clk_audio_counter_wrap;
        ifc.packet_enable = 1'b1;
        tick();
        ifc.packet_enable = 1'b0;
        checks++; if (ifc.packet_type !== 3'd1) $display("FAIL b2b_first got %0d want 1", ifc.packet_type); else passed++;
        tick();
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd1) $display("FAIL b2b_second got %0d want 1", ifc.packet_type); else passed++;
        checks++; if (ifc.acr_missed !== 1'b0) $display("FAIL b2b_missed got %b want 0", ifc.acr_missed); else passed++;
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd0) $display("FAIL b2b_after got %0d want 0", ifc.packet_type); else passed++;
    endtask

    task automatic test_null_run();
        logic [2:0] exp_t [4] = '{3'd2, 3'd2, 3'd2, 3'd3};
        logic rdy;
        do_reset();
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd0 || rdy !== 1'b0) $display("FAIL null_idle got type %0d ready %b want 0/0", ifc.packet_type, rdy); else passed++;
        slot(1'b1, rdy);
        slot(1'b1, rdy);
        checks++; if (ifc.packet_type !== 3'd2) $display("FAIL null_aud got %0d want 2", ifc.packet_type); else passed++;
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd0) $display("FAIL null_break got %0d want 0", ifc.packet_type); else passed++;
        ifc.frame_start = 1'b1;
        tick();
        ifc.frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot(1'b1, rdy);
            checks++; if (ifc.packet_type !== exp_t[i]) $display("FAIL run_type[%0d] got %0d want %0d", i, ifc.packet_type, exp_t[i]); else passed++;
        end
        ifc.audio_valid = 1'b0;
    endtask

    task automatic test_reset_mid_slot();
        logic rdy;
        do_reset();
        ifc.frame_start = 1'b1;
        tick();
        ifc.frame_start = 1'b0;
        ifc.audio_valid = 1'b0;
        ifc.packet_enable = 1'b1;
        tick();
        ifc.packet_enable = 1'b0;
        checks++; if (ifc.packet_type !== 3'd3) $display("FAIL mid_avi got %0d want 3", ifc.packet_type); else passed++;
        reset = 1'b1;
        ifc.packet_enable = 1'b1;
        ifc.audio_valid   = 1'b1;
        #1;
        checks++; if (ifc.audio_ready !== 1'b0) $display("FAIL mid_ready got %b want 0", ifc.audio_ready); else passed++;
        tick();
        ifc.packet_enable = 1'b0;
        ifc.audio_valid   = 1'b0;
        checks++; if (ifc.packet_type !== 3'd0 || ifc.header !== 24'h0) $display("FAIL mid_null got type %0d hdr %h want 0/0", ifc.packet_type, ifc.header); else passed++;
        reset = 1'b0;
        tick();
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd0) $display("FAIL mid_discard got %0d want 0", ifc.packet_type); else passed++;
        ifc.frame_start = 1'b1;
        tick();
        ifc.frame_start = 1'b0;
        slot(1'b0, rdy);
        checks++; if (ifc.packet_type !== 3'd3) $display("FAIL mid_resend got %0d want 3", ifc.packet_type); else passed++;
    endtask

    initial begin
        ifc.clk_audio_counter_wrap = 1'b0;
        ifc.acr_header   = ACR_H;
        ifc.acr_sub      = {4{56'h11111111111111}};
        ifc.audio_valid  = 1'b0;
        ifc.audio_header = AUD_H;
        ifc.audio_sub    = {4{56'h22222222222222}};
        ifc.avi_header   = AVI_H;
        ifc.avi_sub      = {4{56'h33333333333333}};
        ifc.aif_header   = AIF_H;
        ifc.aif_sub      = {4{56'h44444444444444}};
        ifc.frame_start  = 1'b0;
        ifc.packet_enable = 1'b0;
        reset = 1'b1;

        test_reset();
        test_priority();
        test_acr_missed();
        test_back_to_back();
        test_null_run();
        test_reset_mid_slot();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_packet_scheduler.md
HDMI_PACKET_SCHEDULER -- requirements
Module: hdmi_packet_scheduler

Interface
REQ-001 Parameter MAX_CONSECUTIVE_AUDIO, default 3: audio sample slots allowed back-to-back while an infoframe is pending.
REQ-002 clk_pixel  input  1  pixel clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_audio_counter_wrap  input  1  toggle from the ACR packet generator; each transition requests one ACR packet.
REQ-005 acr_header  input  24  and acr_sub  input  4x56  ACR packet contents.
REQ-006 audio_valid  input  1  audio sample packet available.
REQ-007 audio_header  input  24  and audio_sub  input  4x56  audio sample packet.
REQ-008 audio_ready  output  1  audio sample packet consumed this cycle.
REQ-009 avi_header/avi_sub and aif_header/aif_sub  input  24 / 4x56 each  AVI and audio infoframe contents.
REQ-010 frame_start  input  1  one-cycle pulse at the start of each video frame.
REQ-011 packet_enable  input  1  one-cycle pulse marking the start of a 32-pixel data island packet slot.
REQ-012 header  output  24  and sub  output  4x56  selected packet, held for the whole slot.
REQ-013 packet_type  output  3  selected packet: 0 null, 1 ACR, 2 audio, 3 AVI, 4 AIF.
REQ-014 acr_missed  output  1  sticky flag: an ACR request was lost.

Function
REQ-015 prev_wrap register; ACR request edge = clk_audio_counter_wrap XOR prev_wrap, evaluated every cycle.
REQ-016 An ACR edge sets acr_pending.
REQ-017 An ACR edge while acr_pending=1 and ACR not selected that cycle sets acr_missed.
REQ-018 frame_start sets avi_pending and aif_pending.
REQ-019 frame_start while a flag is still set: the flag stays set; not flagged as an error.
REQ-020 Selection only in cycles with packet_enable=1, using the pending flags registered before that cycle.
REQ-021 Priority order: ACR pending; then audio (audio_valid=1 and audio_run < MAX_CONSECUTIVE_AUDIO, or no infoframe pending); then AVI pending; then AIF pending; else null.
REQ-022 audio_ready = packet_enable AND audio selected; combinational; audio inputs sampled in that same cycle.
REQ-023 header, sub and packet_type are registered and update the cycle after packet_enable (latency 1).
REQ-024 Outputs hold until the next update.
REQ-025 Null packet: header=24'h000000, all sub=0.
REQ-026 Selecting a source clears its pending flag in the packet_enable cycle.
REQ-027 A set event in the same cycle as a clear wins: the flag stays 1; acr_missed not set.
REQ-028 audio_run (width clog2(MAX_CONSECUTIVE_AUDIO+1)): increments, saturating, on each audio selection.
REQ-029 audio_run clears on any non-audio selection, including null.
REQ-030 packet_enable for consecutive cycles: each cycle is a full selection; no special handling.
REQ-031 acr_missed clears only on reset.

Reset
REQ-032 On reset: acr_pending, avi_pending, aif_pending, audio_run, acr_missed, header, sub, packet_type all 0.
REQ-033 On reset: prev_wrap loaded with the current clk_audio_counter_wrap, so no spurious ACR request.
REQ-034 During reset: audio_ready=0; packet_enable ignored.
REQ-035 Reset mid-slot: outputs go to null the next cycle; pending requests discarded.

Verification
REQ-036 Reset release, clk_audio_counter_wrap=1, packet_enable pulses -> packet_type=0, header=0, acr_missed=0.
REQ-037 Toggle wrap, frame_start, audio_valid=1, then packet_enable -> slot1 ACR (type 1, header=acr_header, audio_ready=0); next slots audio x3, AVI, audio, AIF (MAX_CONSECUTIVE_AUDIO=3).
REQ-038 Two wrap toggles without packet_enable in between -> acr_missed=1, one ACR packet sent, acr_missed stays 1 until reset.
REQ-039 Wrap toggle in the same cycle as a packet_enable selecting the previous ACR -> acr_pending stays 1, next slot is ACR, acr_missed=0.
REQ-040 audio_valid=0, no pending -> null packets; audio_run=0 after a null slot; a later audio burst gets 3 slots before a pending AVI.
REQ-041 Reset asserted one cycle after packet_enable selecting AVI -> outputs null the next cycle; AVI not sent after release until the next frame_start.
